// File: rtl/systolic_act_feeder_if.sv
// Valid/ready channel carrying one activation vector plus its end-of-matrix tag.
interface systolic_act_feeder_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ROWS   = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [ROWS*DATA_W-1:0] in_data;
  logic                   in_last;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/systolic_act_feeder.sv
// Buffers activation vectors and feeds them diagonally skewed into the left edge of the PE array,
// inserting drain bubbles after each matrix and flagging when its last element reaches the bottom row.
module systolic_act_feeder #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ROWS   = 4,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  systolic_act_feeder_if.slave   in_if,
  output logic [ROWS*DATA_W-1:0] x_out,
  output logic [ROWS-1:0]        x_valid,
  output logic                   done,
  output logic                   busy
);

  localparam int unsigned PtrW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CountW = $clog2(DEPTH) + 1;
  localparam int unsigned CntW   = $clog2(ROWS) + 1;

  typedef enum logic [1:0] {StIdle, StStream, StDrain} state_e;

  state_e                 state_q;
  logic [CntW-1:0]        cnt_q;
  logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CountW-1:0]      count_q;
  logic [ROWS*DATA_W-1:0] mem_data [DEPTH];
  logic [DEPTH-1:0]       mem_last;
  logic [ROWS-1:0]        vld_sr_q, tag_sr_q;

  logic                   full, push, pop, head_last;
  logic [ROWS*DATA_W-1:0] head_data;

  always_comb begin
    full      = (count_q == CountW'(DEPTH));
    push      = in_if.in_valid && !full;
    pop       = (count_q != '0) && (state_q != StDrain);
    head_data = mem_data[rd_ptr_q];
    head_last = mem_last[rd_ptr_q];
  end

  assign in_if.in_ready = !full;

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr_q] <= in_if.in_data;
      mem_last[wr_ptr_q] <= in_if.in_last;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (!push && pop) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle, StStream: begin
          if (pop) begin
            if (head_last) begin
              cnt_q <= CntW'(ROWS - 1);
              if (ROWS > 1) state_q <= StDrain;
              else          state_q <= StIdle;
            end else begin
              state_q <= StStream;
            end
          end
        end
        StDrain: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CntW'(1)) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Valid and last-tag travel one row per cycle; the bottom row's tag is the done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_sr_q <= '0;
      tag_sr_q <= '0;
    end else begin
      vld_sr_q[0] <= pop;
      tag_sr_q[0] <= pop && head_last;
      for (int r = 1; r < ROWS; r++) begin
        vld_sr_q[r] <= vld_sr_q[r-1];
        tag_sr_q[r] <= tag_sr_q[r-1];
      end
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : gen_row
    logic [DATA_W-1:0] sr_q [r+1];

    // Bubbles are zero: PEs accumulate every cycle and have no valid input.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int s = 0; s <= r; s++) sr_q[s] <= '0;
      end else begin
        sr_q[0] <= pop ? head_data[r*DATA_W +: DATA_W] : '0;
        for (int s = 1; s <= r; s++) sr_q[s] <= sr_q[s-1];
      end
    end

    assign x_out[r*DATA_W +: DATA_W] = sr_q[r];
  end

  assign x_valid = vld_sr_q;
  assign done    = tag_sr_q[ROWS-1];
  assign busy    = (state_q != StIdle) || (|vld_sr_q);

endmodule

// File: tb/tb_systolic_act_feeder.sv
// Randomised and directed stimulus for systolic_act_feeder, checked every cycle against a
// queue-based model of the FIFO, the row-0 issue schedule and its diagonal skew.
module tb_systolic_act_feeder;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ROWS   = 4;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned W      = ROWS * DATA_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  systolic_act_feeder_if #(.DATA_W(DATA_W), .ROWS(ROWS)) in_if ();

  logic [W-1:0]    x_out;
  logic [ROWS-1:0] x_valid;
  logic            done;
  logic            busy;

  systolic_act_feeder #(.DATA_W(DATA_W), .ROWS(ROWS), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_if   (in_if),
    .x_out   (x_out),
    .x_valid (x_valid),
    .done    (done),
    .busy    (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending vectors, the history of what row 0 received, and matrix status.
  logic [W-1:0] mq_data [$];
  bit           mq_last [$];
  logic [W-1:0] h_data [ROWS];
  bit           h_vld  [ROWS];
  bit           h_last [ROWS];
  bit           in_matrix;
  int           drain_left;

  logic [W-1:0] pend_d [$];
  bit           pend_l [$];

  function automatic void model_clear();
    mq_data.delete();
    mq_last.delete();
    for (int r = 0; r < ROWS; r++) begin
      h_data[r] = '0;
      h_vld[r]  = 1'b0;
      h_last[r] = 1'b0;
    end
    in_matrix  = 1'b0;
    drain_left = 0;
  endfunction

  function automatic void model_step(input bit v, input logic [W-1:0] d, input bit l);
    bit pop;
    bit acc;
    pop = (mq_data.size() > 0) && (drain_left == 0);
    acc = v && (mq_data.size() < DEPTH);
    for (int r = ROWS - 1; r > 0; r--) begin
      h_data[r] = h_data[r-1];
      h_vld[r]  = h_vld[r-1];
      h_last[r] = h_last[r-1];
    end
    if (pop) begin
      h_data[0] = mq_data.pop_front();
      h_last[0] = mq_last.pop_front();
      h_vld[0]  = 1'b1;
      if (h_last[0]) begin
        in_matrix  = 1'b0;
        drain_left = ROWS - 1;
      end else begin
        in_matrix = 1'b1;
      end
    end else begin
      h_data[0] = '0;
      h_vld[0]  = 1'b0;
      h_last[0] = 1'b0;
      if (drain_left > 0) drain_left--;
    end
    if (acc) begin
      mq_data.push_back(d);
      mq_last.push_back(l);
    end
  endfunction

  task automatic check_outputs();
    logic [W-1:0]    exp_x;
    logic [ROWS-1:0] exp_v;
    bit              any_v;
    any_v = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      exp_x[r*DATA_W +: DATA_W] = h_data[r][r*DATA_W +: DATA_W];
      exp_v[r] = h_vld[r];
      any_v |= h_vld[r];
    end
    check_eq("x_out", 64'(x_out), 64'(exp_x));
    check_eq("x_valid", 64'(x_valid), 64'(exp_v));
    check_eq("done", 64'(done), 64'(h_last[ROWS-1]));
    check_eq("busy", 64'(busy), 64'(in_matrix || (drain_left > 0) || any_v));
    check_eq("in_ready", 64'(in_if.in_ready), 64'(mq_data.size() < DEPTH));
  endtask

  // One clock: check outputs, drive inputs, advance the model, move to the next falling edge.
  task automatic cycle(input bit v, input logic [W-1:0] d, input bit l, output bit acc);
    check_outputs();
    in_if.in_valid = v;
    in_if.in_data  = d;
    in_if.in_last  = l;
    acc = v && (mq_data.size() < DEPTH);
    model_step(v, d, l);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, acc);
  endtask

  task automatic send_pending();
    bit acc;
    for (int i = 0; i < 100 && pend_d.size() > 0; i++) begin
      cycle(1'b1, pend_d[0], pend_l[0], acc);
      if (acc) begin
        void'(pend_d.pop_front());
        void'(pend_l.pop_front());
      end
    end
    check_eq("send_timeout", 64'(pend_d.size()), 64'd0);
    pend_d.delete();
    pend_l.delete();
  endtask

  task automatic queue_vec(input logic [W-1:0] d, input bit l);
    pend_d.push_back(d);
    pend_l.push_back(l);
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    in_if.in_valid = 1'b0;
    in_if.in_data  = '0;
    in_if.in_last  = 1'b0;
    #1;
    model_clear();
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bit acc;
    rst            = 1'b1;
    in_if.in_valid = 1'b0;
    in_if.in_data  = '0;
    in_if.in_last  = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    check_outputs();
    rst = 1'b0;
    idle(2);

    queue_vec(32'h04030201, 1'b1);
    send_pending();
    idle(8);

    queue_vec(32'hA3A2A1A0, 1'b0);
    queue_vec(32'hB3B2B1B0, 1'b0);
    queue_vec(32'hC3C2C1C0, 1'b1);
    queue_vec(32'hD3D2D1D0, 1'b1);
    send_pending();
    idle(10);

    // First vector closes its matrix, so the drain lets the FIFO fill behind it.
    for (int i = 0; i < 6; i++) queue_vec({4{8'(8'h10 + i)}} ^ 32'h00FF00FF, i == 0);
    send_pending();
    idle(12);

    queue_vec(32'h55443322, 1'b0);
    send_pending();
    idle(2);
    queue_vec(32'h99887766, 1'b1);
    send_pending();
    idle(8);

    cycle(1'b1, 32'h11111111, 1'b0, acc);
    cycle(1'b1, 32'h22222222, 1'b0, acc);
    cycle(1'b1, 32'h33333333, 1'b0, acc);
    do_reset();
    idle(3);
    queue_vec(32'h04030201, 1'b1);
    send_pending();
    idle(8);

    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 3) == 0, acc);
      end
    end
    idle(12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule

// File: doc/systolic_act_feeder.md
Name: systolic_act_feeder

Overview:
- Drives the left-edge activation inputs (x_in) of the PE systolic array.
- Accepts one activation vector per valid/ready handshake and buffers it in a small FIFO.
- Skews each vector diagonally so that row r receives its element r cycles after row 0, which is the timing the PE chain requires.
- Tags the end of a matrix, inserts drain bubbles after it, and pulses done when the last element enters the bottom row.

Parameters:
DATA_W, 8, activation width; equal to the global `DATA_W
ROWS, 4, array rows (>=1); one skew lane per row
DEPTH, 4, FIFO depth in vectors (power of 2, >=2)

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  in_data/in_last valid
in_ready  output  1  FIFO can accept a vector
in_data  input  ROWS*DATA_W  activation vector; row r = bits [r*DATA_W +: DATA_W]
in_last  input  1  vector is the final one of a matrix
x_out  output  ROWS*DATA_W  skewed activations to the array's x_in, same packing
x_valid  output  ROWS  per-row valid for x_out lane
done  output  1  one-cycle pulse: last-tagged element is on row ROWS-1
busy  output  1  state!=IDLE or any x_valid/pipeline stage valid

Behaviour:
- Reset (async): x_out=0, x_valid=0, done=0, busy=0, FIFO emptied, state=IDLE, drain counter=0. in_ready=1 after reset.
- All outputs are registered, except in_ready = !full.
- Push:
  - Occurs on an edge with in_valid && in_ready.
  - in_ready does not look ahead at a same-cycle pop: when full it stays 0 even if a pop happens.
  - Simultaneous push and pop with FIFO not full: both take effect and count is unchanged.
- Pop rule: pop on an edge where FIFO is non-empty and state != DRAIN.
- Stage 0 (row 0):
  - On a pop edge, the popped element and last tag load into row 0 with x_valid[0]=1.
  - On a non-pop edge, row 0 loads a bubble: data=0, valid=0, tag=0.
  - Bubbles are driven as zero because PEs have no valid input and accumulate every cycle.
- Skew: rows r>=1 take row r-1's data element r, valid and tag, delayed one stage per row. Row r of a vector popped at edge k appears after edge k+r. Implement as per-row shift registers of depth r.
- done = tag at row ROWS-1 stage, registered identically. It is high exactly in the cycle x_out row ROWS-1 holds the last element. With ROWS=1, done is high in the cycle after the pop edge.
- FSM states:
  - IDLE: on a pop of a non-last vector -> STREAM; on a pop of a last vector -> DRAIN (or stay IDLE if ROWS=1).
  - STREAM: pop when non-empty. If empty, insert a bubble (underrun) and stay in STREAM. On a pop of a last vector -> DRAIN with cnt=ROWS-1 (ROWS=1: -> IDLE).
  - DRAIN: no pops, row 0 gets bubbles; cnt decrements each edge; on the edge where cnt==1 -> IDLE.
- Drain gap: between the last vector of one matrix and the first of the next, row 0 sees exactly ROWS-1 bubble cycles.
- Pushes are accepted in every state, including DRAIN.
- Counter and pointer widths: cnt is $clog2(ROWS)+1 bits. FIFO pointers wrap modulo DEPTH; occupancy count is $clog2(DEPTH)+1 bits.
- Reset mid-operation discards all FIFO content and in-flight skew data. No done is produced for the aborted matrix.

Test Plan:
- Reset, with rst held then released and no input -> x_out=0, x_valid=0, done=0, busy=0, in_ready=1.
- Single last vector, ROWS=4: push in_data={0x04,0x03,0x02,0x01} (row3..row0), in_last=1, popped at edge k:
  - row0=0x01 after k, row1=0x02 after k+1, row2=0x03 after k+2, row3=0x04 after k+3;
  - done=1 only in that final cycle; other lanes read 0 with x_valid=0; busy falls after the done cycle.
- Back-to-back: push A,B,C (C last) then D (next matrix) -> row0 shows A,B,C on 3 consecutive cycles, then 3 bubbles, then D; row3 shows C with done=1.
- Backpressure: hold in_valid=1 with 6 vectors while the first is last (forcing DRAIN) -> in_ready drops when count=4, no vector lost or duplicated, output order is preserved.
- Underrun: push V0, gap 2 cycles, push V1 (last) -> row0 shows V0, 0/0, 0/0, V1; state stays STREAM through the gap; done follows V1 by 3 cycles.
- Reset mid-stream: assert rst after 2 pops of a 4-vector matrix -> outputs clear immediately and no done occurs. After release, a fresh single-vector matrix behaves as in the single-vector test.
